// File: rtl/fp_wb_pkg.sv
// Shared types for the FP writeback path: one buffered FPU result per entry.
package fp_wb_pkg;

    localparam int unsigned WB_DATAWIDTH = 32;
    localparam int unsigned NUM_FREGS    = 32;

    typedef logic [4:0] freg_addr_t;

    typedef struct packed {
        logic [WB_DATAWIDTH-1:0] data;
        freg_addr_t              rd;
        fpnew_pkg::status_t      status;
    } wb_entry_t;

endpackage

// File: rtl/fpnew_pkg.sv
// Exception-status encoding of the FPU result path (NV is the MSB, NX the LSB).
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback entries; the head is read combinationally
// and registered by the consumer. Caller never pushes when full or pops when empty.
module fp_wb_fifo
    import fp_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  wb_entry_t                push_entry_i,
    output wb_entry_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    wb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            r_mem[r_wr_ptr] <= push_entry_i;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so increments wrap on their own.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign full_o  = (r_count == (PW+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

endmodule

// File: rtl/fp_writeback.sv
// FP result writeback: buffers FPU results, writes them to the FP register file,
// tracks pending destinations for issue hazards and accumulates sticky fflags.
module fp_writeback
    import fp_wb_pkg::*;
#(
    parameter int unsigned DATAWIDTH = WB_DATAWIDTH,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [4:0]           issue_rs1_i,
    input  logic [4:0]           issue_rs2_i,
    input  logic [4:0]           issue_rs3_i,
    input  logic [4:0]           issue_rd_i,
    output logic                 hazard_o,
    input  logic                 fpu_valid_i,
    output logic                 fpu_ready_o,
    input  logic [DATAWIDTH-1:0] fpu_result_i,
    input  logic [4:0]           fpu_tag_i,
    input  fpnew_pkg::status_t   fpu_status_i,
    input  logic                 wb_stall_i,
    input  logic                 flush_i,
    input  logic                 fflags_clr_i,
    output logic                 fregwrite_o,
    output logic [4:0]           frd_o,
    output logic [DATAWIDTH-1:0] writeback_data_o,
    output logic [4:0]           fflags_o,
    output logic                 busy_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [NUM_FREGS-1:0]  r_pending;
    logic                  r_fregwrite;
    logic [4:0]            r_frd;
    logic [DATAWIDTH-1:0]  r_wb_data;
    logic [4:0]            r_fflags;

    wb_entry_t             w_push_entry;
    wb_entry_t             w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [NUM_FREGS-1:0]  w_set_vec;
    logic [NUM_FREGS-1:0]  w_clr_vec;

    // Hazard looks only at registered pending bits: a clear is seen one cycle later.
    assign hazard_o      = r_pending[issue_rs1_i] | r_pending[issue_rs2_i]
                         | r_pending[issue_rs3_i] | r_pending[issue_rd_i];
    assign issue_ready_o = rst_ni & ~hazard_o;
    assign fpu_ready_o   = rst_ni & ~w_full;

    assign w_issue = issue_valid_i & issue_ready_o & ~flush_i;
    assign w_push  = fpu_valid_i & fpu_ready_o;
    assign w_pop   = ~w_empty & ~wb_stall_i & ~flush_i;

    assign w_push_entry = '{data: fpu_result_i, rd: fpu_tag_i, status: fpu_status_i};

    fp_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .push_i       (w_push),
        .pop_i        (w_pop),
        .push_entry_i (w_push_entry),
        .head_o       (w_head),
        .full_o       (w_full),
        .empty_o      (w_empty),
        .count_o      (w_count)
    );

    for (genvar gi = 0; gi < NUM_FREGS; gi++) begin : g_score
        assign w_set_vec[gi] = w_issue & (issue_rd_i == freg_addr_t'(gi));
        assign w_clr_vec[gi] = w_pop & (w_head.rd == freg_addr_t'(gi));
    end

    // Set is applied after clear so a same-edge issue of the popped register stays pending.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fregwrite <= 1'b0;
            r_frd       <= '0;
            r_wb_data   <= '0;
            r_fflags    <= '0;
        end else if (flush_i) begin
            r_fregwrite <= 1'b0;
        end else begin
            r_fregwrite <= w_pop;
            if (w_pop) begin
                r_frd     <= w_head.rd;
                r_wb_data <= w_head.data;
                r_fflags  <= (fflags_clr_i ? 5'b0 : r_fflags) | w_head.status;
            end else if (fflags_clr_i) begin
                r_fflags <= '0;
            end
        end
    end

    assign fregwrite_o      = r_fregwrite;
    assign frd_o            = r_frd;
    assign writeback_data_o = r_wb_data;
    assign fflags_o         = r_fflags;
    assign busy_o           = (w_count != '0) | (|r_pending);

endmodule

// File: tb/tb_fp_writeback.sv
// Randomized and directed bench for fp_writeback against a queue-based reference model.
module tb_fp_writeback;
    import fpnew_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni, issue_valid_i, fpu_valid_i, wb_stall_i, flush_i, fflags_clr_i;
    logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rs3_i, issue_rd_i, fpu_tag_i;
    logic [31:0] fpu_result_i;
    status_t     fpu_status_i;
    logic        issue_ready_o, hazard_o, fpu_ready_o, fregwrite_o, busy_o;
    logic [4:0]  frd_o, fflags_o;
    logic [31:0] writeback_data_o;

    fp_writeback dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_rs1_i      (issue_rs1_i),
        .issue_rs2_i      (issue_rs2_i),
        .issue_rs3_i      (issue_rs3_i),
        .issue_rd_i       (issue_rd_i),
        .hazard_o         (hazard_o),
        .fpu_valid_i      (fpu_valid_i),
        .fpu_ready_o      (fpu_ready_o),
        .fpu_result_i     (fpu_result_i),
        .fpu_tag_i        (fpu_tag_i),
        .fpu_status_i     (fpu_status_i),
        .wb_stall_i       (wb_stall_i),
        .flush_i          (flush_i),
        .fflags_clr_i     (fflags_clr_i),
        .fregwrite_o      (fregwrite_o),
        .frd_o            (frd_o),
        .writeback_data_o (writeback_data_o),
        .fflags_o         (fflags_o),
        .busy_o           (busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: results waiting for the register file, plus architectural outputs.
    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [4:0]  st;
    } ent_t;

    ent_t        q[$];
    bit          pend[32];
    logic        m_fw   = 1'b0;
    logic [4:0]  m_frd  = '0;
    logic [31:0] m_data = '0;
    logic [4:0]  m_ff   = '0;

    // One clock cycle: drive inputs, compare every output against the model, advance the model.
    task automatic step(input bit rst, input bit iv, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic [4:0] ad, input bit fv,
                        input logic [31:0] res, input logic [4:0] tg, input logic [4:0] st,
                        input bit stall, input bit fl, input bit clr);
        bit   hz, ir, fr, bz, do_push, do_issue;
        ent_t h;
        @(negedge clk);
        rst_ni        = ~rst;
        issue_valid_i = iv;
        issue_rs1_i   = a1;
        issue_rs2_i   = a2;
        issue_rs3_i   = a3;
        issue_rd_i    = ad;
        fpu_valid_i   = fv;
        fpu_result_i  = res;
        fpu_tag_i     = tg;
        fpu_status_i  = st;
        wb_stall_i    = stall;
        flush_i       = fl;
        fflags_clr_i  = clr;
        #1;
        hz = pend[a1] | pend[a2] | pend[a3] | pend[ad];
        ir = !rst && !hz;
        fr = !rst && (q.size() < DEPTH);
        bz = (q.size() != 0);
        foreach (pend[i]) if (pend[i]) bz = 1'b1;
        check_eq("hazard", 64'(hazard_o), 64'(hz));
        check_eq("issue_ready", 64'(issue_ready_o), 64'(ir));
        check_eq("fpu_ready", 64'(fpu_ready_o), 64'(fr));
        check_eq("busy", 64'(busy_o), 64'(bz));
        check_eq("fregwrite", 64'(fregwrite_o), 64'(m_fw));
        check_eq("frd", 64'(frd_o), 64'(m_frd));
        check_eq("wb_data", 64'(writeback_data_o), 64'(m_data));
        check_eq("fflags", 64'(fflags_o), 64'(m_ff));
        if (fregwrite_o === 1'b1)
            $display("wb: rd=%0d data=%08h fflags=%05b", frd_o, writeback_data_o, fflags_o);

        if (rst) begin
            q.delete();
            foreach (pend[i]) pend[i] = 1'b0;
            m_fw = 1'b0; m_frd = '0; m_data = '0; m_ff = '0;
        end else if (fl) begin
            q.delete();
            foreach (pend[i]) pend[i] = 1'b0;
            m_fw = 1'b0;
        end else begin
            do_push  = fv && fr;
            do_issue = iv && ir;
            if (q.size() > 0 && !stall) begin
                h      = q.pop_front();
                m_fw   = 1'b1;
                m_frd  = h.rd;
                m_data = h.data;
                m_ff   = clr ? h.st : (m_ff | h.st);
                pend[h.rd] = 1'b0;
            end else begin
                m_fw = 1'b0;
                if (clr) m_ff = '0;
            end
            if (do_issue) pend[ad] = 1'b1;
            if (do_push) q.push_back('{data: res, rd: tg, st: st});
        end
    endtask

    task automatic idle(input bit stall, input logic [4:0] a);
        step(0, 0, a, a, a, a, 0, 32'h0, 5'd0, 5'd0, stall, 0, 0);
    endtask

    task automatic push(input logic [4:0] tg, input logic [31:0] d, input logic [4:0] st,
                        input bit stall);
        step(0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 1, d, tg, st, stall, 0, 0);
    endtask

    task automatic issue(input logic [4:0] a1, input logic [4:0] ad);
        step(0, 1, a1, 5'd0, 5'd0, ad, 0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    task automatic setup_flush_case();
        issue(5'd0, 5'd2);
        issue(5'd0, 5'd5);
        push(5'd2, 32'h2222_0002, 5'b00010, 1);
        push(5'd5, 32'h5555_0005, 5'b00001, 1);
    endtask

    initial begin
        rst_ni = 1'b0; issue_valid_i = 1'b0; fpu_valid_i = 1'b0; wb_stall_i = 1'b0;
        flush_i = 1'b0; fflags_clr_i = 1'b0; issue_rs1_i = '0; issue_rs2_i = '0;
        issue_rs3_i = '0; issue_rd_i = '0; fpu_tag_i = '0; fpu_result_i = '0; fpu_status_i = '0;
        foreach (pend[i]) pend[i] = 1'b0;
        repeat (2) @(posedge clk);

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Issue rd=3, return tag 3 with NX, observe write two cycles after the push.
        issue(5'd0, 5'd3);
        step(0, 0, 3, 3, 3, 3, 1, 32'h3F80_0000, 5'd3, 5'b00001, 0, 0, 0);
        check_eq("d_pend3_set", 64'(hazard_o), 64'd1);
        step(0, 1, 3, 0, 0, 9, 0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        check_eq("d_hazard_at_pop", 64'(hazard_o), 64'd1);
        check_eq("d_no_issue_at_pop", 64'(issue_ready_o), 64'd0);
        step(0, 1, 3, 0, 0, 9, 0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        check_eq("d_wb_en", 64'(fregwrite_o), 64'd1);
        check_eq("d_wb_rd", 64'(frd_o), 64'd3);
        check_eq("d_wb_data", 64'(writeback_data_o), 64'h3F80_0000);
        check_eq("d_fflags_nx", 64'(fflags_o), 64'b00001);
        check_eq("d_ready_after_pop", 64'(issue_ready_o), 64'd1);

        // Fill under stall, then drain four writes on consecutive cycles.
        for (int k = 0; k < 4; k++) push(5'(10 + k), 32'hA000_0000 + 32'(k), 5'd0, 1);
        idle(1, 5'd0);
        check_eq("d_full_ready", 64'(fpu_ready_o), 64'd0);
        idle(0, 5'd0);
        check_eq("d_full_ready_pop", 64'(fpu_ready_o), 64'd0);
        for (int k = 0; k < 4; k++) begin
            idle(0, 5'd0);
            check_eq("d_drain_en", 64'(fregwrite_o), 64'd1);
            check_eq("d_drain_rd", 64'(frd_o), 64'(10 + k));
            if (k == 0) check_eq("d_ready_back", 64'(fpu_ready_o), 64'd1);
        end

        // Flag clear coinciding with a pop leaves only the popped status.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push(5'd20, 32'h1111_1111, 5'b10000, 0);
        idle(0, 5'd0);
        push(5'd21, 32'h2121_2121, 5'b00100, 0);
        check_eq("d_fflags_nv", 64'(fflags_o), 64'b10000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 5'd0);
        check_eq("d_fflags_of_only", 64'(fflags_o), 64'b00100);

        // Issue of rd=7 on the same edge as the pop of tag 7 keeps it pending.
        push(5'd7, 32'h7777_7777, 5'd0, 0);
        step(0, 1, 7, 7, 7, 7, 0, 32'h0, 5'd0, 5'd0, 0, 0, 0);
        check_eq("d_issue7_ready", 64'(issue_ready_o), 64'd1);
        idle(0, 5'd7);
        check_eq("d_pend7_kept", 64'(hazard_o), 64'd1);
        push(5'd7, 32'h7777_0000, 5'd0, 0);
        idle(0, 5'd0);
        idle(0, 5'd7);
        check_eq("d_pend7_cleared", 64'(hazard_o), 64'd0);

        // Flush with buffered results and pending registers.
        setup_flush_case();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        check_eq("d_busy_pre_flush", 64'(busy_o), 64'd1);
        idle(0, 5'd0);
        check_eq("d_flush_busy", 64'(busy_o), 64'd0);
        check_eq("d_flush_nowb", 64'(fregwrite_o), 64'd0);
        check_eq("d_flush_fflags", 64'(fflags_o), 64'b00100);
        idle(0, 5'd0);
        check_eq("d_flush_nowb2", 64'(fregwrite_o), 64'd0);

        // Same scenario, reset instead of flush.
        setup_flush_case();
        step(1, 1, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 5'd1, 5'd1, 0, 0, 0);
        check_eq("d_rst_fpu_ready", 64'(fpu_ready_o), 64'd0);
        check_eq("d_rst_issue_ready", 64'(issue_ready_o), 64'd0);
        idle(0, 5'd0);
        check_eq("d_rst_wb", 64'(fregwrite_o), 64'd0);
        check_eq("d_rst_frd", 64'(frd_o), 64'd0);
        check_eq("d_rst_data", 64'(writeback_data_o), 64'd0);
        check_eq("d_rst_fflags", 64'(fflags_o), 64'd0);
        check_eq("d_rst_busy", 64'(busy_o), 64'd0);
        check_eq("d_rst_ready_after", 64'(fpu_ready_o), 64'd1);
        check_eq("d_rst_issue_after", 64'(issue_ready_o), 64'd1);

        // Randomized traffic over a small register range to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 100) == 0, $urandom % 2,
                 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
                 $urandom % 2, $urandom, 5'($urandom % 8), 5'($urandom % 32),
                 ($urandom % 4) == 0, ($urandom % 40) == 0, ($urandom % 10) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
